// File: rtl/bubble_sort.sv
// rtl/bubble_sort.sv - odd-even transposition sorting pipeline; optional BUBBLE_SORT_DESCEND_EN for descending order
module bubble_sort #(
   parameter int DATA_W = 4,
   parameter int DATA_N = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DATA_N-1:0][DATA_W-1:0]  data_in,
   output logic [DATA_N-1:0][DATA_W-1:0]  data_o
);

   typedef logic [DATA_N-1:0][DATA_W-1:0] vec_t;

   // Stage inputs, compare-exchange results, and the stage registers.
   vec_t stage_src [DATA_N];
   vec_t stage_d   [DATA_N];
   vec_t stage_q   [DATA_N];

   // True when the lower-index element must move past the upper-index one.
   // Equal values never swap, so the network is stable in both orders.
   function automatic logic out_of_order(input logic [DATA_W-1:0] lower,
                                         input logic [DATA_W-1:0] upper);
`ifdef BUBBLE_SORT_DESCEND_EN
      return lower < upper;
`else
      return lower > upper;
`endif
   endfunction

   // Chain the stages and apply one layer of compare-exchange per stage:
   // even stages pair (0,1),(2,3)..., odd stages pair (1,2),(3,4)...;
   // an element without a partner passes through untouched.
   always_comb begin
      stage_src[0] = data_in;
      for (int s = 1; s < DATA_N; s++) begin
         stage_src[s] = stage_q[s-1];
      end
      for (int s = 0; s < DATA_N; s++) begin
         stage_d[s] = stage_src[s];
         for (int i = 0; i < DATA_N - 1; i++) begin
            if (((i % 2) == (s % 2)) &&
                out_of_order(stage_src[s][i], stage_src[s][i+1])) begin
               stage_d[s][i]   = stage_src[s][i+1];
               stage_d[s][i+1] = stage_src[s][i];
            end
         end
      end
   end

   // Stage registers: cleared by reset, otherwise advance one stage per cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int s = 0; s < DATA_N; s++) begin
            stage_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < DATA_N; s++) begin
            stage_q[s] <= stage_d[s];
         end
      end
   end

   assign data_o = stage_q[DATA_N-1];

endmodule

// File: tb/tb_bubble_sort.sv
// tb/tb_bubble_sort.sv - directed and random checks of bubble_sort (DATA_W=4, DATA_N=4)
module tb_bubble_sort;

   logic                clk;
   logic                reset;
   logic [3:0][3:0]     data_in;
   logic [3:0][3:0]     data_o;

   int checks;
   int errors;

   logic [15:0] exp_pipe [4];
   logic [15:0] vec;

   bubble_sort #(.DATA_W(4), .DATA_N(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .data_in (data_in),
      .data_o  (data_o)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference sort: insertion sort on four nibbles.
   function automatic logic [15:0] ref_sort(input logic [15:0] v);
      logic [3:0] e [4];
      logic [3:0] t;
      logic [15:0] r;
      int j;
      for (int k = 0; k < 4; k++) e[k] = v[k*4 +: 4];
      for (int k = 1; k < 4; k++) begin
         t = e[k];
         j = k - 1;
         while (j >= 0 && e[j] > t) begin
            e[j+1] = e[j];
            j = j - 1;
         end
         e[j+1] = t;
      end
      r = '0;
      for (int k = 0; k < 4; k++) begin
`ifdef BUBBLE_SORT_DESCEND_EN
         r[k*4 +: 4] = e[3-k];
`else
         r[k*4 +: 4] = e[k];
`endif
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [15:0] expv);
      checks++;
      assert (data_o === expv) else begin
         errors++;
         $error("FAIL %s: data_o=%h expected=%h", tag, data_o, expv);
      end
   endtask

   // One clock: drive inputs at negedge, advance the delay-line model on the
   // edge, and compare data_o against it just after the edge.
   task automatic cycle(input logic [15:0] din, input logic rst);
      @(negedge clk);
      data_in = din;
      reset   = rst;
      @(posedge clk);
      #1;
      if (!rst) begin
         for (int k = 0; k < 4; k++) exp_pipe[k] = '0;
      end else begin
         exp_pipe[3] = exp_pipe[2];
         exp_pipe[2] = exp_pipe[1];
         exp_pipe[1] = exp_pipe[0];
         exp_pipe[0] = ref_sort(din);
      end
      check("pipe", exp_pipe[3]);
   endtask

   logic [15:0] dir_in  [5];
   logic [15:0] dir_exp [5];

   initial begin
      checks  = 0;
      errors  = 0;
      reset   = 1'b0;
      data_in = '0;
      for (int k = 0; k < 4; k++) exp_pipe[k] = '0;

      dir_in[0] = 16'h1234;
      dir_in[1] = 16'h4321;
      dir_in[2] = 16'h2F22;
      dir_in[3] = 16'h0000;
      dir_in[4] = 16'hFFFF;
`ifdef BUBBLE_SORT_DESCEND_EN
      dir_exp[0] = 16'h1234;
      dir_exp[1] = 16'h1234;
      dir_exp[2] = 16'h222F;
      dir_exp[3] = 16'h0000;
      dir_exp[4] = 16'hFFFF;
`else
      dir_exp[0] = 16'h4321;
      dir_exp[1] = 16'h4321;
      dir_exp[2] = 16'hF222;
      dir_exp[3] = 16'h0000;
      dir_exp[4] = 16'hFFFF;
`endif

      // Reset held low with all-ones input: output must read zero every edge.
      for (int k = 0; k < 3; k++) begin
         cycle(16'hFFFF, 1'b0);
         check("reset_zero", 16'h0000);
      end

      // Each directed vector: not visible after 3 edges, sorted after 4.
      for (int d = 0; d < 5; d++) begin
         cycle(dir_in[d], 1'b1);
         cycle(16'h0000, 1'b1);
         cycle(16'h0000, 1'b1);
         check("not_early", 16'h0000);
         cycle(16'h0000, 1'b1);
         check("directed", dir_exp[d]);
      end

      // Back-to-back random stream with a one-cycle reset in the middle.
      for (int n = 0; n < 50; n++) begin
         vec = 16'($urandom());
         cycle(vec, 1'b1);
         if (n == 25) begin
            cycle(vec, 1'b0);
            check("midreset_zero", 16'h0000);
            cycle(16'h1234, 1'b1);
            check("post_reset_hold", 16'h0000);
            vec = 16'($urandom());
            cycle(vec, 1'b1);
            check("post_reset_hold", 16'h0000);
            vec = 16'($urandom());
            cycle(vec, 1'b1);
            check("post_reset_hold", 16'h0000);
            vec = 16'($urandom());
            cycle(vec, 1'b1);
            check("post_reset_first", dir_exp[0]);
         end
      end

      // Drain the pipeline.
      for (int k = 0; k < 4; k++) cycle(16'h0000, 1'b1);
      check("drained", 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bubble_sort.md
BUBBLE_SORT -- requirements
Module: bubble_sort

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the bit width of each element.
REQ-002 Parameter DATA_N, default 4, SHALL set the element count per vector; values of 2 or more SHALL be supported.
REQ-003 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-low, on clock clk.
REQ-005 data_in  input  [DATA_N-1:0][DATA_W-1:0] packed  SHALL carry the unsorted vector; element i is data_in[i].
REQ-006 data_o  output  [DATA_N-1:0][DATA_W-1:0] packed  SHALL carry the sorted vector, driven directly from registers.

Function
REQ-007 Elements SHALL be compared as unsigned DATA_W-bit values.
REQ-008 Default order SHALL be ascending: data_o[0] is the smallest element, data_o[DATA_N-1] the largest.
REQ-009 The block SHALL be an odd-even transposition pipeline of exactly DATA_N registered stages, s = 0..DATA_N-1.
REQ-010 Stage 0 SHALL operate on data_in; each later stage SHALL operate on the previous stage's register.
REQ-011 Even stages SHALL compare-exchange pairs (0,1),(2,3),...; odd stages SHALL compare-exchange pairs (1,2),(3,4),...
REQ-012 An element with no partner in a stage SHALL pass through that stage unchanged.
REQ-013 A pair SHALL swap only when the lower-index element is strictly greater; equal elements SHALL not swap.
REQ-014 data_o SHALL be the register of stage DATA_N-1.
REQ-015 Latency: a vector sampled on rising edge t SHALL appear sorted on data_o after edge t+DATA_N-1 (DATA_N cycles).
REQ-016 Throughput SHALL be one vector per cycle; a new data_in SHALL be accepted every cycle, with no stalls and no handshake.
REQ-017 The output SHALL be a permutation of the input multiset; no element SHALL be lost or duplicated.
REQ-018 data_in is sampled every cycle; X on data_in SHALL propagate only through the pipeline slots that carry it.

Reset
REQ-019 While reset is low at a rising edge, every pipeline stage register, including data_o, SHALL load all zeros.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight vectors on that edge.
REQ-021 After reset deasserts, data_o SHALL stay zero until the first post-reset vector emerges DATA_N cycles later.
REQ-022 While reset is low, data_in SHALL be ignored.

Configuration
REQ-023 Macro BUBBLE_SORT_DESCEND_EN, when defined, SHALL invert every compare-exchange so that data_o[0] is the largest element.
REQ-024 With BUBBLE_SORT_DESCEND_EN defined, equal elements SHALL still not swap.
REQ-025 Without the macro, ascending order per REQ-008 SHALL apply.
REQ-026 Latency, reset and throughput SHALL be identical with and without BUBBLE_SORT_DESCEND_EN.

Verification (DATA_W=4, DATA_N=4; vectors written as packed hex {e3,e2,e1,e0})
REQ-027 Reset: hold reset low for 3 cycles with data_in=16'hFFFF -> data_o=16'h0000 at every edge.
REQ-028 Reverse input: data_in=16'h1234 for 1 cycle after reset release -> data_o=16'h4321 exactly 4 cycles later.
REQ-029 Sorted input and duplicates:
- 16'h4321 -> 16'h4321.
- 16'h2F22 -> 16'hF222.
- 16'h0000 -> 16'h0000.
- 16'hFFFF -> 16'hFFFF.
REQ-030 Back-to-back: 50 consecutive $urandom vectors, one per cycle -> each output equals the reference sort of the input 4 cycles earlier, in order, with no gaps.
REQ-031 Mid-stream reset: assert reset for 1 cycle during the random stream -> data_o=0 on the next edge, then nonzero results resume 4 cycles after the first post-reset vector.
REQ-032 With BUBBLE_SORT_DESCEND_EN defined: data_in=16'h4321 -> data_o=16'h1234 after 4 cycles.
